// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter / next-address stage.
//   Computes the branch target (br_pc4 + br_offset_sh), picks branch over jump,
//   and drives the instruction-fetch address under a valid/ready handshake.
//   Redirects that arrive while the fetch is stalled are parked in pend_target
//   and applied once fetch_ready returns. flush/align_err are registered
//   one-cycle pulses aligned with the first cycle of the redirected pc_out.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   br_offset_sh, br_pc4       branch offset (already <<2) and branch PC+4
//   br_taken                   branch resolved taken
//   jmp_valid, jmp_target      jump resolved, absolute target
//   fetch_ready                instruction memory accepts pc_out
//   pc_out, fetch_valid        fetch request
//   flush                      discard IF/ID contents
//   align_err                  applied redirect target had nonzero bits [1:0]
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] br_offset_sh,
    input  logic [31:0] br_pc4,
    input  logic        br_taken,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        fetch_ready,
    output logic [31:0] pc_out,
    output logic        fetch_valid,
    output logic        flush,
    output logic        align_err
);
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pend_target, pend_n, pc_n;
    logic        pend_mis, pend_mis_n;   // misalignment flag of the parked target
    logic        flush_n, align_n;

    logic [31:0] br_target, raw_target, target;
    logic        redirect, mis;

    // Single combinational path: adder -> priority mux -> pc mux -> pc_out reg.
    assign br_target  = br_pc4 + br_offset_sh;              // carry dropped
    assign raw_target = br_taken ? br_target : jmp_target;  // branch wins
    assign redirect   = br_taken | jmp_valid;
    assign target     = {raw_target[31:2], 2'b00};
    assign mis        = |raw_target[1:0];

    assign fetch_valid = (state != BOOT);

    always_comb begin
        state_n    = state;
        pc_n       = pc_out;
        pend_n     = pend_target;
        pend_mis_n = pend_mis;
        flush_n    = 1'b0;
        align_n    = 1'b0;
        case (state)
            BOOT: state_n = RUN;  // redirects ignored here
            RUN: begin
                if (redirect) begin
                    if (fetch_ready) begin
                        pc_n    = target;
                        flush_n = 1'b1;
                        align_n = mis;
                    end else begin
                        pend_n     = target;
                        pend_mis_n = mis;
                        state_n    = HOLD;
                    end
                end else if (fetch_ready) begin
                    pc_n = pc_out + 32'd4;
                end
            end
            HOLD: begin
                // Latest redirect replaces the parked one.
                if (redirect) begin
                    pend_n     = target;
                    pend_mis_n = mis;
                end
                if (fetch_ready) begin
                    pc_n    = redirect ? target : pend_target;
                    align_n = redirect ? mis : pend_mis;
                    flush_n = 1'b1;
                    state_n = RUN;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_out      <= RESET_PC;
            pend_target <= 32'h0;
            pend_mis    <= 1'b0;
            flush       <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pc_out      <= pc_n;
            pend_target <= pend_n;
            pend_mis    <= pend_mis_n;
            flush       <= flush_n;
            align_err   <= align_n;
        end
    end
endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] br_offset_sh = '0, br_pc4 = '0, jmp_target = '0;
    logic        br_taken = 1'b0, jmp_valid = 1'b0, fetch_ready = 1'b1;
    logic [31:0] pc_out;
    logic        fetch_valid, flush, align_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ae;
        string       name;
    } exp_t;

    exp_t sb[$];

    pc_next_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_offset_sh(br_offset_sh), .br_pc4(br_pc4), .br_taken(br_taken),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target), .fetch_ready(fetch_ready),
        .pc_out(pc_out), .fetch_valid(fetch_valid), .flush(flush), .align_err(align_err)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (pc_out !== e.pc || fetch_valid !== e.fv || flush !== e.fl || align_err !== e.ae) begin
                bad++;
                $display("FAIL %s: got pc=%h fv=%b flush=%b ae=%b, want pc=%h fv=%b flush=%b ae=%b",
                         e.name, pc_out, fetch_valid, flush, align_err, e.pc, e.fv, e.fl, e.ae);
            end
        end
    end

    task automatic push(input logic [31:0] pc, input logic fv, input logic fl,
                        input logic ae, input string name);
        exp_t e;
        e.pc = pc; e.fv = fv; e.fl = fl; e.ae = ae; e.name = name;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, then record the expected post-edge outputs.
    task automatic step(input logic bt, input logic [31:0] pc4, input logic [31:0] off,
                        input logic jv, input logic [31:0] jt, input logic fr,
                        input logic [31:0] epc, input logic efl, input logic eae,
                        input string name);
        br_taken = bt; br_pc4 = pc4; br_offset_sh = off;
        jmp_valid = jv; jmp_target = jt; fetch_ready = fr;
        @(posedge clk);
        #1;
        br_taken = 1'b0; jmp_valid = 1'b0;
        push(epc, 1'b1, efl, eae, name);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 push(32'h0, 1'b0, 1'b0, 1'b0, "reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Boot and sequential fetch
        step(0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, "boot_first_valid");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0004, 0, 0, "seq_4");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0008, 0, 0, "seq_8");
        // Jump to 0x100, then taken branch 0x104+0x10
        step(0, 0, 0, 1, 32'h100, 1, 32'h0000_0100, 1, 0, "jmp_100");
        step(1, 32'h104, 32'h10, 0, 0, 1, 32'h0000_0114, 1, 0, "br_114");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0118, 0, 0, "after_br_118");
        // Adder wrap cases
        step(1, 32'hFFFF_FFFC, 32'h8, 0, 0, 1, 32'h0000_0004, 1, 0, "wrap_up");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0008, 0, 0, "wrap_up_next");
        step(1, 32'h8, 32'hFFFF_FFF0, 0, 0, 1, 32'hFFFF_FFF8, 1, 0, "wrap_down");
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, "seq_fffc");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, "pc_wrap_0");
        // Branch beats jump in the same cycle
        step(1, 32'h1FC, 32'h4, 1, 32'h400, 1, 32'h0000_0200, 1, 0, "br_over_jmp");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0204, 0, 0, "seq_204");
        // Stall: branch to 0x300, later jump to 0x500, latest wins
        step(1, 32'h2F0, 32'h10, 0, 0, 0, 32'h0000_0204, 0, 0, "hold_br");
        step(0, 0, 0, 0, 0, 0, 32'h0000_0204, 0, 0, "hold_1");
        step(0, 0, 0, 0, 0, 0, 32'h0000_0204, 0, 0, "hold_2");
        step(0, 0, 0, 1, 32'h500, 0, 32'h0000_0204, 0, 0, "hold_jmp");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0500, 1, 0, "hold_release");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0504, 0, 0, "after_release");
        // Misaligned jump target
        step(0, 0, 0, 1, 32'h502, 1, 32'h0000_0500, 1, 1, "misalign_jmp");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0504, 0, 0, "misalign_clear");
        // Misaligned target parked during a stall
        step(0, 0, 0, 1, 32'h5FE, 0, 32'h0000_0504, 0, 0, "hold_misalign");
        step(0, 0, 0, 0, 0, 1, 32'h0000_05FC, 1, 1, "hold_misalign_apply");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0600, 0, 0, "seq_600");
        // Redirect arriving on the release cycle overrides the parked one
        step(0, 0, 0, 1, 32'h700, 0, 32'h0000_0600, 0, 0, "hold_700");
        step(0, 0, 0, 1, 32'h800, 1, 32'h0000_0800, 1, 0, "release_new_800");
        step(0, 0, 0, 0, 0, 0, 32'h0000_0800, 0, 0, "run_stall_holds");
        // Reset asserted mid-HOLD
        step(0, 0, 0, 1, 32'h900, 0, 32'h0000_0800, 0, 0, "hold_900");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (pc_out !== 32'h0 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got pc=%h fv=%b flush=%b, want pc=00000000 fv=0 flush=0",
                     pc_out, fetch_valid, flush);
        end
        fetch_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, "post_reset_boot");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0004, 0, 0, "post_reset_4");
        step(0, 0, 0, 0, 0, 1, 32'h0000_0008, 0, 0, "post_reset_8");

        // Let the monitor drain, bounded
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
